// File: rtl/data_ram_arbiter_if.sv
// Purpose : bundle of the two requester ports and the data RAM port of data_ram_arbiter.
// Latency : none, wires only.
// Backpressure: none here; requesters hold req until gnt.
// Ports   : slave  = arbiter view (requests in, grants/responses/RAM drive out)
//           master = environment view (requesters plus RAM model)
interface data_ram_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [DATA_W-1:0] addr0, addr1;
  logic [3:0]        sel0, sel1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, sel0, sel1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_en, ram_we, ram_addr, ram_sel, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, sel0, sel1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_en, ram_we, ram_addr, ram_sel, ram_wdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Purpose : shares the single-port data RAM between port 0 (MEM stage) and port 1 (aux master).
// Latency : gnt in cycle T (combinational), RAM access T+1, rvalid/rdata T+2; one access per 3 cycles.
// Backpressure: requesters hold req until gnt; no grant outside IDLE.
// Ports   : clk, rst (sync, active-high), bus (data_ram_arbiter_if.slave).
// Config  : DRAM_ARB_RR_EN defined -> round-robin on conflict; undefined -> port 0 fixed priority.
//           Either way a port that lost STARVE_LIMIT conflicts in a row wins the next one.
module data_ram_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  data_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic [3:0] starve_t;
  localparam starve_t LIMIT = starve_t'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic              grant_any;
  logic              win;            // 0 = port 0, 1 = port 1
  logic              cmd_we, cmd_port;
  logic [DATA_W-1:0] cmd_addr, cmd_wdata;
  logic [3:0]        cmd_sel;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  starve_t           starve0, starve1;
`ifdef DRAM_ARB_RR_EN
  logic              last_winner;
`endif

  // Winner selection; starvation overrides the policy, port 0 first if both starve.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      if (starve0 == LIMIT)      win = 1'b0;
      else if (starve1 == LIMIT) win = 1'b1;
      else begin
`ifdef DRAM_ARB_RR_EN
        win = ~last_winner;
`else
        win = 1'b0;
`endif
      end
    end else begin
      win = bus.req1;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_any = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are masked during reset so nothing is accepted on the reset edge.
  assign bus.gnt0      = grant_any && !rst && !win;
  assign bus.gnt1      = grant_any && !rst &&  win;
  assign bus.ram_en    = (state == ACCESS);
  assign bus.ram_we    = (state == ACCESS) && cmd_we;
  assign bus.ram_addr  = cmd_addr;
  assign bus.ram_sel   = cmd_sel;
  assign bus.ram_wdata = cmd_wdata;
  assign bus.rvalid0   = (state == RESP) && !cmd_port;
  assign bus.rvalid1   = (state == RESP) &&  cmd_port;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_addr  <= '0;
      cmd_sel   <= '0;
      cmd_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      starve0   <= '0;
      starve1   <= '0;
`ifdef DRAM_ARB_RR_EN
      last_winner <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        cmd_port  <= win;
        cmd_we    <= win ? bus.we1    : bus.we0;
        cmd_addr  <= win ? bus.addr1  : bus.addr0;
        cmd_sel   <= win ? bus.sel1   : bus.sel0;
        cmd_wdata <= win ? bus.wdata1 : bus.wdata0;
`ifdef DRAM_ARB_RR_EN
        last_winner <= win;
`endif
        // Winner's counter clears; the other one only counts if it was also requesting.
        if (win) begin
          starve1 <= '0;
          if (bus.req0 && starve0 != LIMIT) starve0 <= starve0 + 4'd1;
        end else begin
          starve0 <= '0;
          if (bus.req1 && starve1 != LIMIT) starve1 <= starve1 + 4'd1;
        end
      end
      // Read data is combinational from ram_addr, so capture it at the end of ACCESS.
      if (state == ACCESS) begin
        if (cmd_port) rdata1_q <= cmd_we ? '0 : bus.ram_rdata;
        else          rdata0_q <= cmd_we ? '0 : bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.DATA_W(DATA_W)) bus();

  data_ram_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM model: clocked byte-lane write, combinational read, cleared by reset.
  logic [31:0] ram [256];
  assign bus.ram_rdata = ram[bus.ram_addr[9:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (bus.ram_en && bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_sel[b]) ram[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  // Reference state kept by the bench.
  logic [31:0] shadow [256];
  logic [31:0] exp_rd [2];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          wait_cyc;
    logic        en, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        rv, rv_other, rv_after;
    logic [31:0] rd;
  } obs_t;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic clear_model();
    foreach (shadow[i]) shadow[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(int p, bit req, bit we, logic [31:0] a, logic [3:0] s, logic [31:0] wd);
    if (p == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.sel0 = s; bus.wdata0 = wd;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.sel1 = s; bus.wdata1 = wd;
    end
  endtask

  // Issues one access from port p starting at posedge+1; returns what was seen.
  task automatic run_access(input int p, input bit we, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] wd, output obs_t o);
    o.wait_cyc = 0;
    drive_port(p, 1'b1, we, a, s, wd);
    #1;
    while (((p == 0) ? bus.gnt0 : bus.gnt1) !== 1'b1 && o.wait_cyc < 10) begin
      @(posedge clk);
      #2;
      o.wait_cyc++;
    end
    @(posedge clk);
    #1;
    drive_port(p, 1'b0, 1'b0, '0, '0, '0);
    o.en   = bus.ram_en;
    o.we   = bus.ram_we;
    o.addr = bus.ram_addr;
    o.sel  = bus.ram_sel;
    o.wdat = bus.ram_wdata;
    @(posedge clk);
    #1;
    o.rv       = (p == 0) ? bus.rvalid0 : bus.rvalid1;
    o.rv_other = (p == 0) ? bus.rvalid1 : bus.rvalid0;
    o.rd       = (p == 0) ? bus.rdata0  : bus.rdata1;
    step();
    o.rv_after = (p == 0) ? bus.rvalid0 : bus.rvalid1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_port(0, 1'b1, 1'b0, 32'h4, 4'hF, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    #1;
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b required 00", {bus.gnt0, bus.gnt1});
    end
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 0000", {bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we});
    end
    n_checks++;
    if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h required 0", bus.rdata0, bus.rdata1);
    end
    n_checks++;
    if ({bus.ram_addr, bus.ram_sel, bus.ram_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_ram_bus: got %h %h %h required 0", bus.ram_addr, bus.ram_sel, bus.ram_wdata);
    end
    step();
    drive_port(0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_store_load();
    obs_t o;
    run_access(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, o);
    shadow[8'h40] = merge(shadow[8'h40], 32'hDEADBEEF, 4'hF);
    n_checks++;
    if (o.wait_cyc !== 0) begin n_fail++; $display("FAIL store_gnt_latency: got %0d required 0", o.wait_cyc); end
    n_checks++;
    if ({o.en, o.we} !== 2'b11) begin n_fail++; $display("FAIL store_ram_en_we: got %b required 11", {o.en, o.we}); end
    n_checks++;
    if ({o.addr, o.sel, o.wdat} !== {32'h100, 4'hF, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL store_ram_cmd: got %h %h %h required 100 f deadbeef", o.addr, o.sel, o.wdat);
    end
    n_checks++;
    if ({o.rv, o.rv_other, o.rv_after} !== 3'b100) begin
      n_fail++; $display("FAIL store_rvalid: got %b required 100", {o.rv, o.rv_other, o.rv_after});
    end
    n_checks++;
    if (o.rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h required 0", o.rd); end
    run_access(0, 1'b0, 32'h100, 4'hF, 32'h0, o);
    n_checks++;
    if ({o.en, o.we} !== 2'b10) begin n_fail++; $display("FAIL load_ram_en_we: got %b required 10", {o.en, o.we}); end
    n_checks++;
    if (o.rv !== 1'b1 || o.rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_rdata: got rv=%b %h required rv=1 deadbeef", o.rv, o.rd);
    end
    exp_rd[0] = 32'hDEADBEEF;
  endtask

  task automatic test_byte_lanes();
    obs_t o;
    logic [31:0] junk;
    run_access(0, 1'b1, 32'h200, 4'hF, 32'hFFFFFFFF, o);
    run_access(0, 1'b1, 32'h200, 4'b0101, 32'h11223344, o);
    run_access(0, 1'b0, 32'h200, 4'hF, 32'h0, o);
    n_checks++;
    if (o.rd !== 32'hFF22FF44) begin n_fail++; $display("FAIL lanes_0101: got %h required ff22ff44", o.rd); end
    junk = $urandom;
    run_access(1, 1'b1, 32'h200, 4'b0000, junk, o);
    run_access(1, 1'b0, 32'h200, 4'hF, 32'h0, o);
    n_checks++;
    if (o.rd !== 32'hFF22FF44) begin n_fail++; $display("FAIL lanes_0000: got %h required ff22ff44", o.rd); end
    shadow[8'h80] = 32'hFF22FF44;
    exp_rd[0] = 32'hFF22FF44;
    exp_rd[1] = 32'hFF22FF44;
  endtask

  task automatic test_random();
    obs_t o;
    for (int it = 0; it < 40; it++) begin
      int p;
      bit we;
      logic [7:0] idx;
      logic [3:0] s;
      logic [31:0] wd, exp;
      p   = $urandom_range(0, 1);
      we  = $urandom_range(0, 1);
      idx = 8'($urandom_range(0, 15));
      s   = 4'($urandom);
      wd  = $urandom;
      run_access(p, we, {22'h0, idx, 2'b00}, s, wd, o);
      if (we) begin
        shadow[idx] = merge(shadow[idx], wd, s);
        exp = '0;
      end else begin
        exp = shadow[idx];
      end
      exp_rd[p] = exp;
      n_checks++;
      if (o.rv !== 1'b1 || o.rv_other !== 1'b0) begin
        n_fail++; $display("FAIL rand_rvalid it%0d: got %b%b required 10", it, o.rv, o.rv_other);
      end
      n_checks++;
      if (o.rd !== exp) begin n_fail++; $display("FAIL rand_rdata it%0d port%0d: got %h required %h", it, p, o.rd, exp); end
      n_checks++;
      if (o.we !== we || o.addr !== {22'h0, idx, 2'b00}) begin
        n_fail++; $display("FAIL rand_cmd it%0d: got we=%b addr=%h required we=%b addr=%h", it, o.we, o.addr, we, {22'h0, idx, 2'b00});
      end
      n_checks++;
      if (((p == 0) ? bus.rdata1 : bus.rdata0) !== exp_rd[1-p]) begin
        n_fail++; $display("FAIL rand_hold it%0d: got %h required %h", it, (p == 0) ? bus.rdata1 : bus.rdata0, exp_rd[1-p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, grants = 0, rvs = 0, last_g = -100;
    drive_port(1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    while (rvs < 4 && cyc < 40) begin
      #1;
      if (bus.gnt1) begin
        if (grants > 0) begin
          n_checks++;
          if (cyc - last_g !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d required 3", cyc - last_g); end
        end
        last_g = cyc;
        grants++;
      end
      if (bus.rvalid1) begin
        rvs++;
        n_checks++;
        if (cyc - last_g !== 2 || bus.rdata1 !== shadow[8'h80]) begin
          n_fail++; $display("FAIL b2b_resp: got delay %0d data %h required 2 %h", cyc - last_g, bus.rdata1, shadow[8'h80]);
        end
        n_checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++; $display("FAIL b2b_gnt_in_resp: got %b required 00", {bus.gnt0, bus.gnt1}); end
      end
      step();
      cyc++;
      if (grants == 4) drive_port(1, 1'b0, 1'b0, '0, '0, '0);
    end
    exp_rd[1] = shadow[8'h80];
    n_checks++;
    if (grants !== 4 || rvs !== 4) begin n_fail++; $display("FAIL b2b_counts: got %0d grants %0d rvalids required 4 4", grants, rvs); end
  endtask

  task automatic test_conflict();
    int cyc = 0, k = 0, last_g = 0, exp_w;
    int exp_cnt [2];
    int rv_cnt [2];
    exp_cnt[0] = 0; exp_cnt[1] = 0; rv_cnt[0] = 0; rv_cnt[1] = 0;
    apply_reset();
    drive_port(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    drive_port(1, 1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
    while ((k < 12 || cyc < last_g + 3) && cyc < 80) begin
      #1;
      if (bus.gnt0 || bus.gnt1) begin
`ifdef DRAM_ARB_RR_EN
        exp_w = (k % 2 == 0) ? 0 : 1;
`else
        exp_w = (k % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? 1 : 0;
`endif
        n_checks++;
        if ({bus.gnt1, bus.gnt0} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL conflict_grant k%0d: got gnt1gnt0=%b required port %0d", k, {bus.gnt1, bus.gnt0}, exp_w);
        end
        exp_cnt[exp_w]++;
        last_g = cyc;
        k++;
      end
      if (bus.rvalid0) rv_cnt[0]++;
      if (bus.rvalid1) rv_cnt[1]++;
      step();
      cyc++;
      if (k == 12) begin
        drive_port(0, 1'b0, 1'b0, '0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    n_checks++;
    if (k !== 12 || rv_cnt[0] !== exp_cnt[0] || rv_cnt[1] !== exp_cnt[1]) begin
      n_fail++; $display("FAIL conflict_resp: got %0d grants rv %0d/%0d required 12 rv %0d/%0d", k, rv_cnt[0], rv_cnt[1], exp_cnt[0], exp_cnt[1]);
    end
  endtask

  task automatic test_mid_reset();
    obs_t o;
    apply_reset();
    drive_port(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL midrst_first_gnt: got %b required 1", bus.gnt0); end
    step();
    drive_port(0, 1'b0, 1'b0, '0, '0, '0);
    n_checks++;
    if (bus.ram_en !== 1'b1) begin n_fail++; $display("FAIL midrst_access: got ram_en %b required 1", bus.ram_en); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.ram_en} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_abort: got %b required 000", {bus.rvalid0, bus.rvalid1, bus.ram_en});
    end
    run_access(0, 1'b0, 32'h100, 4'hF, 32'h0, o);
    n_checks++;
    if (o.wait_cyc !== 0 || o.rv !== 1'b1 || o.rd !== 32'h0) begin
      n_fail++; $display("FAIL midrst_fresh: got wait %0d rv %b rd %h required 0 1 0", o.wait_cyc, o.rv, o.rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_random();
    test_back_to_back();
    test_conflict();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
